// File: rtl/seq_gen_pkg.sv
// Shared types and defaults for the serial pattern generator.
package seq_gen_pkg;

  // Engine selection: counter + mux, or rotating shift register.
  typedef enum logic {IMPL_CNT, IMPL_SHIFT} seq_impl_e;

  localparam int                   DEFAULT_LEN     = 6;
  localparam logic [DEFAULT_LEN-1:0] DEFAULT_PATTERN = 6'b001011;

  // Width of a modulo-len phase counter (at least one bit).
  function automatic int cnt_width(input int len);
    return (len > 2) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/seq_gen_core.sv
// One pattern engine: emits SEQ_PATTERN MSB first, one bit per clk, forever.
// IMPL picks a counter-indexed mux or a rotating register. In both cases
// sync comes from a modulo-SEQ_LEN phase counter so it is independent of
// the pattern content.
module seq_gen_core
  import seq_gen_pkg::*;
#(
  parameter int                 SEQ_LEN     = DEFAULT_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = DEFAULT_PATTERN,
  parameter seq_impl_e          IMPL        = IMPL_CNT
) (
  input  logic clk,
  input  logic rst,
  output logic data,
  output logic sync
);

  localparam int            CW   = cnt_width(SEQ_LEN);
  localparam logic [CW-1:0] LAST = CW'(SEQ_LEN - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_data;
  logic          r_sync;

  // Next phase value: count up and wrap from SEQ_LEN-1 back to 0.
  always_comb begin
    // NOTE: every signal written here gets a value before any condition, so no latch can be inferred.
    w_cnt_nxt = r_cnt + CW'(1);
    if (r_cnt == LAST) begin
      w_cnt_nxt = '0;
    end
  end

  // Phase counter and sync pulse; sync marks the edge that sends bit index 0.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_cnt  <= '0;
      r_sync <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_sync <= (r_cnt == '0);
    end
  end

  if (IMPL == IMPL_CNT) begin : g_cnt
    logic [CW-1:0] w_idx;

    // Phase 0 selects the MSB, phase SEQ_LEN-1 the LSB.
    assign w_idx = LAST - r_cnt;

    // Counter engine: registered mux of the constant pattern.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_data <= 1'b0;
      end else begin
        r_data <= SEQ_PATTERN[w_idx];
      end
    end
  end else begin : g_shift
    logic [SEQ_LEN-1:0] r_shreg;

    // Shift engine: send the MSB, then rotate left so the pattern recirculates.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        // NOTE: the rotating register resets to the pattern itself, not zero; it is the pattern store.
        r_shreg <= SEQ_PATTERN;
        r_data  <= 1'b0;
      end else begin
        r_data  <= r_shreg[SEQ_LEN-1];
        r_shreg <= {r_shreg[SEQ_LEN-2:0], r_shreg[SEQ_LEN-1]};
      end
    end
  end

  assign data = r_data;
  assign sync = r_sync;

endmodule

// File: rtl/seq_pattern_gen.sv
// Free-running serial pattern source (top).
// Build option: define SEQ_GEN_LOCKSTEP_EN to run both engines side by side
// and raise a sticky err when their data streams diverge. Without it only
// the IMPL-selected engine exists and err is constant 0.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int                 SEQ_LEN     = DEFAULT_LEN,
  parameter logic [SEQ_LEN-1:0] SEQ_PATTERN = DEFAULT_PATTERN,
  parameter seq_impl_e          IMPL        = IMPL_CNT
) (
  input  logic clk,
  input  logic rst,
  output logic data,
  output logic sync,
  output logic err
);

`ifdef SEQ_GEN_LOCKSTEP_EN
  logic w_data_cnt;
  logic w_sync_cnt;
  logic w_data_shift;
  logic w_sync_shift;
  logic w_mismatch;
  logic r_err;

  seq_gen_core #(
    .SEQ_LEN     (SEQ_LEN),
    .SEQ_PATTERN (SEQ_PATTERN),
    .IMPL        (IMPL_CNT)
  ) u_core_cnt (
    .clk  (clk),
    .rst  (rst),
    .data (w_data_cnt),
    .sync (w_sync_cnt)
  );

  seq_gen_core #(
    .SEQ_LEN     (SEQ_LEN),
    .SEQ_PATTERN (SEQ_PATTERN),
    .IMPL        (IMPL_SHIFT)
  ) u_core_shift (
    .clk  (clk),
    .rst  (rst),
    .data (w_data_shift),
    .sync (w_sync_shift)
  );

  assign data       = (IMPL == IMPL_CNT) ? w_data_cnt : w_data_shift;
  assign sync       = (IMPL == IMPL_CNT) ? w_sync_cnt : w_sync_shift;
  assign w_mismatch = w_data_cnt ^ w_data_shift;

  // Sticky mismatch record; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  // err shows on the very edge the streams first differ, then holds.
  assign err = r_err | w_mismatch;
`else
  seq_gen_core #(
    .SEQ_LEN     (SEQ_LEN),
    .SEQ_PATTERN (SEQ_PATTERN),
    .IMPL        (IMPL)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .sync (sync)
  );

  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus pushes the expected
// {data,sync,err} for each upcoming edge, a monitor pops and compares
// shortly after every rising edge.
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  typedef struct packed {
    logic data;
    logic sync;
    logic err;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic d_cnt, s_cnt, e_cnt;
  logic d_shf, s_shf, e_shf;
  logic d_ovr, s_ovr, e_ovr;

  int n_checks = 0;
  int n_fail   = 0;

  obs_t q_cnt[$];
  obs_t q_shf[$];
  obs_t q_ovr[$];

  // Hand-written expected streams, MSB of the pattern first.
  logic pat6 [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};  // 6'b001011
  logic pat4 [4] = '{1'b1, 1'b0, 1'b0, 1'b1};              // 4'b1001

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .SEQ_LEN(6), .SEQ_PATTERN(6'b001011), .IMPL(IMPL_CNT)
  ) u_cnt (
    .clk(clk), .rst(rst), .data(d_cnt), .sync(s_cnt), .err(e_cnt)
  );

  seq_pattern_gen #(
    .SEQ_LEN(6), .SEQ_PATTERN(6'b001011), .IMPL(IMPL_SHIFT)
  ) u_shf (
    .clk(clk), .rst(rst), .data(d_shf), .sync(s_shf), .err(e_shf)
  );

  seq_pattern_gen #(
    .SEQ_LEN(4), .SEQ_PATTERN(4'b1001), .IMPL(IMPL_SHIFT)
  ) u_ovr (
    .clk(clk), .rst(rst), .data(d_ovr), .sync(s_ovr), .err(e_ovr)
  );

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got data=%b sync=%b err=%b, expected data=%b sync=%b err=%b",
               name, $time, act.data, act.sync, act.err, exp.data, exp.sync, exp.err);
    end
  endtask

  // k = 0 means "in reset"; k >= 1 is the k-th edge after release.
  function automatic obs_t exp6(input int k);
    obs_t e = '0;
    if (k > 0) begin
      e.data = pat6[(k - 1) % 6];
      e.sync = ((k - 1) % 6 == 0);
    end
    return e;
  endfunction

  function automatic obs_t exp4(input int k);
    obs_t e = '0;
    if (k > 0) begin
      e.data = pat4[(k - 1) % 4];
      e.sync = ((k - 1) % 4 == 0);
    end
    return e;
  endfunction

  task automatic push_all(input int k);
    q_cnt.push_back(exp6(k));
    q_shf.push_back(exp6(k));
    q_ovr.push_back(exp4(k));
  endtask

  // Called at a falling edge: hold reset for n rising edges.
  task automatic hold_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      push_all(0);
      @(negedge clk);
    end
  endtask

  // Called at a falling edge: release reset and expect n pattern bits.
  task automatic run_stream(input int n);
    rst = 1'b0;
    for (int k = 1; k <= n; k++) begin
      push_all(k);
      @(negedge clk);
    end
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset_check(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_cnt"}, {d_cnt, s_cnt, e_cnt}, '0);
    check({tag, "_shf"}, {d_shf, s_shf, e_shf}, '0);
    check({tag, "_ovr"}, {d_ovr, s_ovr, e_ovr}, '0);
  endtask

  // Monitor: one expected entry per DUT per rising edge, sampled 1 time unit later.
  always @(posedge clk) begin
    obs_t e;
    #1;
    if (q_cnt.size() > 0) begin
      e = q_cnt.pop_front();
      check("cnt", {d_cnt, s_cnt, e_cnt}, e);
    end
    if (q_shf.size() > 0) begin
      e = q_shf.pop_front();
      check("shf", {d_shf, s_shf, e_shf}, e);
    end
    if (q_ovr.size() > 0) begin
      e = q_ovr.pop_front();
      check("ovr", {d_ovr, s_ovr, e_ovr}, e);
    end
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    hold_reset(10);

    // Long run from release: pattern, sync spacing, engine agreement.
    run_stream(200);

    // Reset after the 4th bit (data=0), then restart from bit index 0.
    hold_reset(2);
    run_stream(4);
    async_reset_check("mid4");
    hold_reset(2);

    // Reset after the 5th bit, where data=1 (and the LEN-4 sync is high).
    run_stream(5);
    async_reset_check("mid5");
    hold_reset(1);
    run_stream(12);
    hold_reset(2);

`ifdef SEQ_GEN_LOCKSTEP_EN
    // Corrupt the shift engine while the counter engine is about to send a 0.
    rst = 1'b0;
    @(negedge clk);
    check("lock_before", {1'b0, 1'b0, e_cnt}, '0);
    force u_cnt.u_core_shift.g_shift.r_shreg = 6'b111111;
    @(negedge clk);
    check("lock_rise", {1'b0, 1'b0, e_cnt}, 3'b001);
    release u_cnt.u_core_shift.g_shift.r_shreg;
    repeat (10) @(negedge clk);
    check("lock_sticky", {1'b0, 1'b0, e_cnt}, 3'b001);
    rst = 1'b1;
    #1;
    check("lock_clear", {1'b0, 1'b0, e_cnt}, '0);
    @(negedge clk);
`endif

    // Bounded drain of anything still queued.
    for (int i = 0; i < 20; i++) begin
      if (q_cnt.size() == 0 && q_shf.size() == 0 && q_ovr.size() == 0) break;
      @(negedge clk);
    end
    if (q_cnt.size() != 0 || q_shf.size() != 0 || q_ovr.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d/%0d/%0d entries left, expected 0",
               q_cnt.size(), q_shf.size(), q_ovr.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
